pc_fetch_unit: RTL and testbench

- Program-counter register plus instruction-fetch sequencer.
- Sits directly downstream of mux_pc: consumes its pc_out as pc_next, holds the current PC and fetches the instruction at that PC from instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction to decode with a valid/ready handshake. pc_out feeds back to the PC+4 adder and branch-target logic that drive mux_pc.

---
 rtl/pc_fetch_unit_pkg.sv | 19 +
 rtl/pc_reg.sv | 24 ++
 rtl/pc_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC register / instruction-fetch sequencer.
// Holds the address width, the default reset vector, the NOP word used for
// misaligned-fetch traps and the fetch FSM state encoding.
package pc_fetch_unit_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // addi x0, x0, 0 : presented in place of a misaligned fetch
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: DATA_WIDTH bits, synchronous active-high reset
// to RESET_VECTOR, loads d when load is high.
module pc_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // PC storage with reset and load enable
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VECTOR;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus instruction-fetch sequencer.
// Fetches the instruction at pc over a req/gnt/rvalid handshake (one request
// outstanding at a time) and presents it to decode on instr_valid/instr_ready.
//
// Handshakes: imem side - imem_req is held with a stable imem_addr until a
// cycle with imem_gnt; the single response arrives on a later cycle with
// imem_rvalid. Decode side - instr_out/pc_out are held while instr_valid is
// high and are consumed in a cycle where instr_valid and instr_ready are both
// high. flush overrides everything: it reloads pc from pc_next and drops any
// held or in-flight instruction (a granted-but-unanswered response is
// swallowed via the drop flag).
//
// Optional build macro PC_MISALIGN_TRAP_EN: a misaligned pc is never
// requested; a NOP is presented instead with fetch_fault raised.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int                    INSTR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  pc_next,
  input  logic                   flush,
  output logic                   imem_req,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0]  pc_out,
  output logic                   fetch_fault,
  output logic [31:0]            fetch_count,
  output fetch_state_e           state_dbg
);

  fetch_state_e          state;
  logic                  drop;
  logic                  misaligned;
  logic                  granted;
  logic                  pc_load;
  logic [DATA_WIDTH-1:0] pc;

`ifdef PC_MISALIGN_TRAP_EN
  logic fault_q;
  assign misaligned  = |pc[1:0];
  assign fetch_fault = !rst && fault_q;
`else
  assign misaligned  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign imem_req    = !rst && (state == FS_REQ) && !misaligned;
  assign imem_addr   = pc;
  assign instr_valid = !rst && (state == FS_HOLD);
  assign pc_out      = pc;
  assign state_dbg   = state;
  assign granted     = imem_req && imem_gnt;

  // pc follows pc_next on every flush and on every consumed instruction
  assign pc_load = flush || ((state == FS_HOLD) && instr_ready);

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .d   (pc_next),
    .q   (pc)
  );

  // Fetch FSM, drop flag, held instruction and consumed-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FS_REQ;
      drop        <= 1'b0;
      instr_out   <= '0;
      fetch_count <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      case (state)
        FS_REQ: begin
          if (flush) begin
            // a grant in the flush cycle still belongs to the old address
            if (granted) begin
              drop  <= 1'b1;
              state <= FS_WAIT;
            end
          end else if (misaligned) begin
            instr_out <= INSTR_WIDTH'(NOP_INSTR);
            state     <= FS_HOLD;
`ifdef PC_MISALIGN_TRAP_EN
            fault_q   <= 1'b1;
`endif
          end else if (granted) begin
            state <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (flush) begin
            if (imem_rvalid) begin
              drop  <= 1'b0;
              state <= FS_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= FS_REQ;
            end else begin
              instr_out <= imem_rdata;
              state     <= FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (flush) begin
            state <= FS_REQ;
`ifdef PC_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
          end else if (instr_ready) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= FS_REQ;
`ifdef PC_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
          end
        end
        default: begin
          state <= FS_REQ;
          drop  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a transaction-level
// reference model of the fetch protocol.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        fetch_fault;
  logic [31:0] fetch_count;
  fetch_state_e state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .INSTR_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_next    (pc_next),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .fetch_fault(fetch_fault),
    .fetch_count(fetch_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- reference model ----------------
  // Tracks what the fetch unit owes: a request still to be issued, a
  // response still to arrive (and whether it must be thrown away), or an
  // instruction sitting in front of decode.
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  bit          m_need_req;
  bit          m_in_flight;
  bit          m_discard;
  bit          m_have;
  bit          m_fault;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_count;

  function automatic bit m_bad_addr();
    return TRAP_ON && (m_pc[1:0] != 2'b00);
  endfunction

  function automatic bit m_req_out();
    return !rst && m_need_req && !m_bad_addr();
  endfunction

  // advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    bit took_grant;
    took_grant = m_req_out() && imem_gnt;
    if (rst) begin
      m_need_req = 1; m_in_flight = 0; m_discard = 0; m_have = 0;
      m_fault = 0; m_pc = 32'h0; m_instr = 32'h0; m_count = 32'h0;
    end else if (m_need_req) begin
      if (flush) begin
        m_pc = pc_next;
        if (took_grant) begin
          m_need_req = 0; m_in_flight = 1; m_discard = 1;
        end
      end else if (m_bad_addr()) begin
        m_need_req = 0; m_have = 1; m_instr = NOP_INSTR; m_fault = 1;
      end else if (took_grant) begin
        m_need_req = 0; m_in_flight = 1;
      end
    end else if (m_in_flight) begin
      if (flush) begin
        m_pc = pc_next;
        if (imem_rvalid) begin
          m_in_flight = 0; m_need_req = 1; m_discard = 0;
        end else begin
          m_discard = 1;
        end
      end else if (imem_rvalid) begin
        m_in_flight = 0;
        if (m_discard) begin
          m_discard = 0; m_need_req = 1;
        end else begin
          m_instr = imem_rdata; m_have = 1;
        end
      end
    end else if (m_have) begin
      if (flush || instr_ready) begin
        if (!flush) m_count = m_count + 32'd1;
        m_pc = pc_next; m_have = 0; m_fault = 0; m_need_req = 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("imem_req",    {31'b0, imem_req},    {31'b0, m_req_out()});
    chk("imem_addr",   imem_addr,            m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, !rst && m_have});
    chk("instr_out",   instr_out,            m_instr);
    chk("pc_out",      pc_out,               m_pc);
    chk("fetch_count", fetch_count,          m_count);
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, !rst && m_fault});
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    flush = 0; imem_gnt = 0; imem_rvalid = 0; instr_ready = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; pc_next = 32'h0; imem_rdata = 32'h0;
    idle_inputs();
    m_pc = 32'hx; m_count = 32'hx; m_instr = 32'hx;

    // reset
    step(); step();
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_count", fetch_count, 32'h0);
    chk("reset_req", {31'b0, imem_req}, 32'h0);

    // release: request for address 0 appears immediately
    rst = 0; #1;
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    // minimum-latency fetch
    imem_gnt = 1; step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093; step();
    chk("first_instr", instr_out, 32'h0050_0093);
    chk("first_valid", {31'b0, instr_valid}, 32'h1);
    imem_rvalid = 0; instr_ready = 1; pc_next = 32'h4; step();
    chk("pc_after_consume", pc_out, 32'h4);
    chk("count_after_consume", fetch_count, 32'h1);

    // memory backpressure: grant withheld, then response delayed
    idle_inputs();
    repeat (3) begin
      step();
      chk("bp_addr_stable", imem_addr, 32'h4);
    end
    imem_gnt = 1; step();
    imem_gnt = 0; step(); step();
    chk("bp_no_valid_early", {31'b0, instr_valid}, 32'h0);
    imem_rvalid = 1; imem_rdata = $urandom; step();
    imem_rvalid = 0;

    // decode stall
    repeat (4) step();
    chk("stall_count", fetch_count, 32'h1);
    instr_ready = 1; pc_next = 32'h8; step();
    instr_ready = 0;

    // flush while waiting for the response: data must be dropped
    imem_gnt = 1; step();
    imem_gnt = 0; flush = 1; pc_next = 32'h40; step();
    flush = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step();
    imem_rvalid = 0;
    chk("dropped_not_shown", {31'b0, instr_out == 32'hDEAD_BEEF}, 32'h0);
    chk("refetch_addr", imem_addr, 32'h40);

    // flush together with ready in hold: not consumed
    imem_gnt = 1; step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = $urandom; step();
    imem_rvalid = 0; instr_ready = 1; flush = 1; pc_next = 32'h44; step();
    idle_inputs();
    chk("flush_ready_count", fetch_count, 32'h2);
    chk("flush_ready_valid", {31'b0, instr_valid}, 32'h0);

    // reset in the middle of a fetch, then a late response
    imem_gnt = 1; step();
    imem_gnt = 0; rst = 1; step();
    rst = 0; imem_rvalid = 1; imem_rdata = $urandom; step();
    imem_rvalid = 0;
    chk("midreset_pc", pc_out, 32'h0);
    chk("midreset_count", fetch_count, 32'h0);
    chk("late_rvalid_ignored", {31'b0, instr_valid}, 32'h0);

    // misaligned pc
    flush = 1; pc_next = 32'h6; step();
    flush = 0;
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign_no_req", {31'b0, imem_req}, 32'h0);
    step();
    chk("misalign_nop", instr_out, 32'h0000_0013);
    chk("misalign_fault", {31'b0, fetch_fault}, 32'h1);
`else
    chk("misalign_req", {31'b0, imem_req}, 32'h1);
    chk("misalign_addr", imem_addr, 32'h6);
    chk("misalign_nofault", {31'b0, fetch_fault}, 32'h0);
    imem_gnt = 1; step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = $urandom; step();
    imem_rvalid = 0;
`endif
    instr_ready = 1; pc_next = 32'h8; step();
    instr_ready = 0;
    chk("misalign_consumed", fetch_count, 32'h1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 79) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      imem_gnt    = ($urandom_range(0, 1) == 1);
      imem_rvalid = ($urandom_range(0, 1) == 1);
      instr_ready = ($urandom_range(0, 1) == 1);
      imem_rdata  = $urandom;
      pc_next     = $urandom;
      if ($urandom_range(0, 7) != 0) pc_next[1:0] = 2'b00;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
